// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and default constants for the RSA datapath (mod_exp, mod_mul)
package rsa_pkg;

  // Default operand width and exponent bit-index width
  localparam int K_DEF    = 192;
  localparam int LOGK_DEF = 8;

  // Default odd modulus m = 2^192 - 2^64 - 1 with its Montgomery constants (R = 2^k)
  localparam logic [191:0] M_DEF  = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
  localparam logic [191:0] R1_DEF = 192'h1_0000_0000_0000_0001;
  localparam logic [191:0] R2_DEF = 192'h1_0000_0000_0000_0002_0000_0000_0000_0001;

  // Cycles per Montgomery multiply, ISSUE to next possible ISSUE
  localparam int T_MM = K_DEF + 3;

  // Exponentiator phase states
  typedef enum logic [2:0] {
    PH_IDLE,
    PH_LOAD,
    PH_CONV_IN,
    PH_SQR,
    PH_MUL,
    PH_CONV_OUT,
    PH_DONE
  } phase_e;

  // Handshake sub-phase used for every multiplier call
  typedef enum logic [1:0] {
    SUB_ISSUE,
    SUB_WAIT,
    SUB_REL
  } sub_e;

  // Montgomery multiplier states
  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } mm_state_e;

endpackage

// File: rtl/mod_exp_if.sv
// rtl/mod_exp_if.sv - start/done request bus between the top-level controller and mod_exp
interface mod_exp_if
  import rsa_pkg::*;
#(
  parameter int k = K_DEF
) ();
  logic         start;
  logic [k-1:0] x;
  logic [k-1:0] e;
  logic [k-1:0] z;
  logic         done;
  logic         busy;

  modport master (output start, x, e, input z, done, busy);
  modport slave  (input start, x, e, output z, done, busy);
endinterface

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - bit-serial radix-2 Montgomery multiplier z = a*b*2^-k mod m, level start/done
module mod_mul
  import rsa_pkg::*;
#(
  parameter int           k    = K_DEF,
  parameter int           logk = LOGK_DEF,
  parameter logic [k-1:0] m    = M_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [k-1:0] a_i,
  input  logic [k-1:0] b_i,
  output logic [k-1:0] z_o,
  output logic         done_o
);

  localparam logic [logk-1:0] LAST = logk'(k - 1);

  mm_state_e       st_q;
  logic [k:0]      acc_q;
  logic [logk-1:0] cnt_q;

  logic       a_bit;
  logic [k:0] acc_base;
  logic [k+1:0] sum;
  logic [k:0] step_res;
  logic [k:0] red;

  // One Montgomery step: acc = (acc + a[i]*b + q*m) / 2; the first step runs in IDLE from acc=0
  always_comb begin
    a_bit    = (st_q == MM_IDLE) ? a_i[0] : a_i[cnt_q];
    acc_base = (st_q == MM_IDLE) ? '0 : acc_q;
    sum      = {1'b0, acc_base} + (a_bit ? {2'b00, b_i} : '0);
    if (sum[0]) begin
      sum = sum + {2'b00, m};
    end
    step_res = sum[k+1:1];
    red      = (step_res >= {1'b0, m}) ? (step_res - {1'b0, m}) : step_res;
  end

  // Iterate k steps, reduce once on the last, hold the result until start drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= MM_IDLE;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (st_q)
        MM_IDLE: begin
          if (start_i) begin
            acc_q <= step_res;
            cnt_q <= logk'(1);
            st_q  <= MM_RUN;
          end
        end
        MM_RUN: begin
          if (cnt_q == LAST) begin
            acc_q <= red;
            st_q  <= MM_DONE;
          end else begin
            acc_q <= step_res;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MM_DONE: begin
          if (!start_i) begin
            st_q <= MM_IDLE;
          end
        end
        default: st_q <= MM_IDLE;
      endcase
    end
  end

  assign z_o    = acc_q[k-1:0];
  assign done_o = (st_q == MM_DONE);

endmodule

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - MSB-first Montgomery square-and-multiply z = x^e mod m; MOD_EXP_CONST_TIME_EN runs MUL for every bit
module mod_exp
  import rsa_pkg::*;
#(
  parameter int           k    = K_DEF,
  parameter int           logk = LOGK_DEF,
  parameter logic [k-1:0] m    = M_DEF,
  parameter logic [k-1:0] R1   = R1_DEF,
  parameter logic [k-1:0] R2   = R2_DEF
) (
  input  logic     clk,
  input  logic     rst,
  mod_exp_if.slave bus
);

  phase_e          phase_q;
  sub_e            sub_q;
  logic [logk-1:0] i_q;
  logic [k-1:0]    x_q;
  logic [k-1:0]    e_q;
  logic [k-1:0]    acc_q;
  logic [k-1:0]    xbar_q;
  logic [k-1:0]    z_q;
  logic            done_q;
  logic            busy_q;
  logic            mm_start_q;

  logic [k-1:0] mm_a;
  logic [k-1:0] mm_b;
  logic [k-1:0] mm_z;
  logic         mm_done;

  phase_e rel_phase_d;
  logic   i_dec_d;
  logic   last_bit;
  phase_e bit_next;

  // Operand mux selected by the registered phase, so it is stable for the whole call
  always_comb begin
    mm_a = acc_q;
    mm_b = acc_q;
    case (phase_q)
      PH_CONV_IN: begin
        mm_a = x_q;
        mm_b = R2;
      end
      PH_MUL:      mm_b = xbar_q;
      PH_CONV_OUT: mm_b = k'(1);
      default: ;
    endcase
  end

  // Phase to enter after the REL sub-phase, including the next-bit decision
  always_comb begin
    last_bit    = (i_q == '0);
    bit_next    = last_bit ? PH_CONV_OUT : PH_SQR;
    rel_phase_d = phase_q;
    i_dec_d     = 1'b0;
    case (phase_q)
      PH_CONV_IN: rel_phase_d = PH_SQR;
      PH_SQR: begin
`ifdef MOD_EXP_CONST_TIME_EN
        rel_phase_d = PH_MUL;
`else
        if (e_q[i_q]) begin
          rel_phase_d = PH_MUL;
        end else begin
          rel_phase_d = bit_next;
          i_dec_d     = !last_bit;
        end
`endif
      end
      PH_MUL: begin
        rel_phase_d = bit_next;
        i_dec_d     = !last_bit;
      end
      PH_CONV_OUT: rel_phase_d = PH_DONE;
      default: ;
    endcase
  end

  // Phase/handshake controller with registered outputs and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_IDLE;
      sub_q      <= SUB_ISSUE;
      i_q        <= '0;
      x_q        <= '0;
      e_q        <= '0;
      acc_q      <= '0;
      xbar_q     <= '0;
      z_q        <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (bus.start) begin
            phase_q <= PH_LOAD;
            busy_q  <= 1'b1;
          end
        end
        PH_LOAD: begin
          x_q     <= bus.x;
          e_q     <= bus.e;
          acc_q   <= R1;
          i_q     <= logk'(k - 1);
          sub_q   <= SUB_ISSUE;
          phase_q <= PH_CONV_IN;
        end
        PH_CONV_IN, PH_SQR, PH_MUL, PH_CONV_OUT: begin
          case (sub_q)
            SUB_ISSUE: begin
              mm_start_q <= 1'b1;
              sub_q      <= SUB_WAIT;
            end
            SUB_WAIT: begin
              if (mm_done) begin
                mm_start_q <= 1'b0;
                sub_q      <= SUB_REL;
                case (phase_q)
                  PH_CONV_IN: xbar_q <= mm_z;
                  PH_SQR:     acc_q  <= mm_z;
                  PH_MUL: begin
`ifdef MOD_EXP_CONST_TIME_EN
                    if (e_q[i_q]) begin
                      acc_q <= mm_z;
                    end
`else
                    acc_q <= mm_z;
`endif
                  end
                  default:    z_q    <= mm_z;
                endcase
              end
            end
            default: begin
              sub_q   <= SUB_ISSUE;
              phase_q <= rel_phase_d;
              if (i_dec_d) begin
                i_q <= i_q - 1'b1;
              end
              if (rel_phase_d == PH_DONE) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end
          endcase
        end
        PH_DONE: begin
          if (!bus.start) begin
            done_q  <= 1'b0;
            phase_q <= PH_IDLE;
          end
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  mod_mul #(
    .k    (k),
    .logk (logk),
    .m    (m)
  ) u_mod_mul (
    .clk     (clk),
    .rst_n   (~rst),
    .start_i (mm_start_q),
    .a_i     (mm_a),
    .b_i     (mm_b),
    .z_o     (mm_z),
    .done_o  (mm_done)
  );

  assign bus.z    = z_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/mod_exp.md
# mod_exp

Modular exponentiator computing z = x^e mod m over k-bit operands, with MSB-first square-and-multiply in the Montgomery domain. It is the initiator that drives the team's `mod_mul` Montgomery multiplier through its start/done level handshake. It sequences the domain conversion, the per-bit square and multiply steps, and the conversion back. It sits above `mod_mul` in the RSA datapath and presents its own start/done handshake to the top-level controller.

## Interface
- `k`, 192: operand width in bits.
- `logk`, 8: width of the exponent bit index.
- `m`, 192'hfffffffffffffffffffffffffffffffeffffffffffffffff: odd modulus. Must match the `m` of the instanced `mod_mul`.
- `R1`, 2^64+1: R mod m, where R = 2^k. This is Montgomery "one". The default matches the default `m`.
- `R2`, 2^128+2^65+1: R^2 mod m. The default matches the default `m`.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request. Level-held until `done` is seen.
- `x`, input, k: base. Must satisfy x < m. Sampled in LOAD.
- `e`, input, k: exponent. Sampled in LOAD.
- `z`, output, k: result. Valid while `done`=1.
- `done`, output, 1: result valid.
- `busy`, output, 1: set from LOAD until DONE is entered.

## Operation
- Phase FSM states: IDLE, LOAD, CONV_IN, SQR, MUL, CONV_OUT, DONE.
  - IDLE→LOAD when `start`=1.
  - LOAD: latch x and e, set acc=R1, set bit index i=k-1. Then go to CONV_IN.
  - CONV_IN: xbar = MM(x, R2). Then go to SQR.
  - SQR: acc = MM(acc, acc). Then go to MUL if e[i]=1, else go to the next bit.
  - MUL: acc = MM(acc, xbar). Then go to the next bit.
  - Next bit: if i=0, go to CONV_OUT; otherwise decrement i and go to SQR.
  - CONV_OUT: z = MM(acc, 1). Then go to DONE.
  - DONE: `done`=1. Stay while `start`=1; go to IDLE when `start`=0.
- Each MM operation uses a handshake sub-phase: ISSUE → WAIT → REL.
  - ISSUE (1 cycle): drive operands, set registered `mm_start`=1.
  - WAIT: hold `mm_start` and operands until `mm_done`=1, then capture `mm_z` into the destination register in that same cycle.
  - REL (1 cycle): `mm_start`=0. This lets `mod_mul` return to its IDLE state. The next ISSUE may follow immediately.
- Operand muxes are held stable from ISSUE through the `mm_done` cycle.
- `mod_mul` reset is driven with `rst_n` = ~`rst`.
- Arithmetic: all registers are k bits. `mod_mul` output is already fully reduced (< m), so no extra subtraction is needed.
- Boundary conditions:
  - e=0: z=1.
  - x=0 with e≠0: z=0.
  - x ≥ m: input contract violation, result unspecified.
  - `start` deasserted mid-operation: ignored. The operation completes and DONE exits on the first cycle with `start`=0.

## Timing
- Reset values: `z`=0, `done`=0, `busy`=0, `mm_start`=0, FSM=IDLE.
- Reset mid-operation aborts within one cycle. `mod_mul` is reset by the same edge.
- One MM operation costs T_mm = k+3 cycles from ISSUE to the next possible ISSUE.
- Latency: with `start` sampled in IDLE at cycle 0, `done` rises at cycle 2 + N·(k+3).
  - N = k + 2 + popcount(e) without the macro.
  - N = 2k + 2 with the macro.
- `z` changes only on the CONV_OUT capture cycle.

## Configuration
- `MOD_EXP_CONST_TIME_EN` defined: MUL runs for every bit. acc is written only when e[i]=1; otherwise the product is discarded. Latency is fixed and independent of e.
- Not defined: MUL is skipped for zero bits, so latency depends on popcount(e).

## Structure
- Package `rsa_pkg`:
  - phase-state and handshake sub-phase enums;
  - default `m`, `R1`, `R2`;
  - T_MM = k+3.
- One sub-module: a `mod_mul` instance (`u_mod_mul`). The controller, operand muxes and acc/xbar/z registers are in `mod_exp`.

## Test plan
- x=2, e=3 → z=8. Without the macro, `done` rises at cycle 2+196·195 = 38222.
- Same stimulus with `MOD_EXP_CONST_TIME_EN` → z=8, `done` at cycle 2+386·195 = 75272.
- e=0, x=5 → z=1. x=0, e=5 → z=0. x=m-1, e=2 → z=1.
- x=3, e=m-1 (Fermat) → z=1. Check against a reference model for 20 random (x<m, e) pairs.
- Hold `start` 10 cycles after `done` → `done` and `z` stay stable. Drop `start` → `done`=0 next cycle and FSM returns to IDLE.
- Assert `rst` during the 50th MM op → next cycle `busy`=0, `done`=0, `z`=0, `mm_start`=0. A fresh start with x=2, e=3 → z=8.
